// File: rtl/mul_rr_arbiter.sv
// mul_rr_arbiter
//   Shares one pipelined W x W unsigned multiplier between NREQ requesters.
//   A round-robin arbiter accepts at most one operand pair per cycle; the
//   low W bits of the product come back LAT cycles after the accepting edge,
//   tagged one-hot with the requester that issued it. Ordering is FIFO.
//
// Ports
//   clk         in   1       clock, all state on rising edge
//   rst_n       in   1       asynchronous active-low reset
//   flush       in   1       synchronous drop of all in-flight ops, rr pointer -> 0
//   req_valid   in   NREQ    per-requester operand valid
//   req_ready   out  NREQ    one-hot grant (combinational), 0 in reset or flush
//   req_a       in   NREQ*W  operand A, requester i at [i*W +: W]
//   req_b       in   NREQ*W  operand B, requester i at [i*W +: W]
//   resp_valid  out  NREQ    one-hot result strobe, single-cycle pulse
//   resp_data   out  W       (a*b)[W-1:0], holds last value when resp_valid=0
//   busy        out  1       any op held in a pipeline stage

module mul_rr_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned W    = 32,
    parameter int unsigned LAT  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   resp_valid,
    output logic [W-1:0]      resp_data,
    output logic              busy
);

    localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // ------------------------------------------------------------------
    // Operand unpacking
    // ------------------------------------------------------------------
    logic [W-1:0] w_a_arr [NREQ];
    logic [W-1:0] w_b_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign w_a_arr[i] = req_a[i*W +: W];
        assign w_b_arr[i] = req_b[i*W +: W];
    end

    // ------------------------------------------------------------------
    // Round-robin arbiter
    // ------------------------------------------------------------------
    logic [IdxW-1:0] r_rr_ptr;
    logic [IdxW-1:0] w_grant_idx;
    logic [IdxW-1:0] w_next_ptr;
    logic [NREQ-1:0] w_grant_onehot;
    logic            w_any;
    logic            w_issue;

    // Scan rr_ptr, rr_ptr+1, ... (mod NREQ); the first valid requester wins.
    always_comb begin
        int unsigned     v_idx;
        logic [IdxW-1:0] v_cand;
        v_idx       = 0;
        v_cand      = '0;
        w_any       = 1'b0;
        w_grant_idx = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            v_idx  = (32'(r_rr_ptr) + k) % NREQ;
            v_cand = IdxW'(v_idx);
            if (!w_any && req_valid[v_cand]) begin
                w_any       = 1'b1;
                w_grant_idx = v_cand;
            end
        end
    end

    assign w_grant_onehot = NREQ'(1) << w_grant_idx;

    // Grant is independent of pipeline state: the pipe takes one op per cycle.
    assign req_ready = (rst_n && !flush && w_any) ? w_grant_onehot : '0;
    assign w_issue   = |req_ready;

    assign w_next_ptr = (w_grant_idx == IdxW'(NREQ - 1)) ? '0 : w_grant_idx + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if (flush) begin
            r_rr_ptr <= '0;
        end else if (w_issue) begin
            r_rr_ptr <= w_next_ptr;
        end
    end

    // ------------------------------------------------------------------
    // Pipeline control: one-hot tag per stage, all-zero means empty
    // ------------------------------------------------------------------
    logic [NREQ-1:0] r_stage_tag [LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < LAT; s++) begin
                r_stage_tag[s] <= '0;
            end
        end else if (flush) begin
            for (int s = 0; s < LAT; s++) begin
                r_stage_tag[s] <= '0;
            end
        end else begin
            r_stage_tag[0] <= req_ready;
            for (int s = 1; s < LAT; s++) begin
                r_stage_tag[s] <= r_stage_tag[s-1];
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int s = 0; s < LAT; s++) begin
            busy = busy | (|r_stage_tag[s]);
        end
    end

    // ------------------------------------------------------------------
    // Datapath: stage 0 holds operands, later stages hold the product
    // ------------------------------------------------------------------
    logic [W-1:0] r_op_a;
    logic [W-1:0] r_op_b;
    logic [W-1:0] w_prod_lo;
    logic [W-1:0] w_stage_prod [LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_a <= '0;
            r_op_b <= '0;
        end else if (w_issue) begin
            r_op_a <= w_a_arr[w_grant_idx];
            r_op_b <= w_b_arr[w_grant_idx];
        end
    end

    // Multiply at the full 2W width, then keep the low W bits.
    assign w_prod_lo = W'({{W{1'b0}}, r_op_a} * {{W{1'b0}}, r_op_b});

    assign w_stage_prod[0] = w_prod_lo;

    for (genvar s = 1; s < LAT; s++) begin : g_prod_stage
        logic [W-1:0] r_prod;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_prod <= '0;
            end else if (|r_stage_tag[s-1]) begin
                r_prod <= w_stage_prod[s-1];
            end
        end

        assign w_stage_prod[s] = r_prod;
    end

    // ------------------------------------------------------------------
    // Response register
    // ------------------------------------------------------------------
    logic [NREQ-1:0] r_resp_valid;
    logic [W-1:0]    r_resp_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_valid <= '0;
            r_resp_data  <= '0;
        end else begin
            // A flush also kills the op that would retire on the same edge.
            r_resp_valid <= flush ? '0 : r_stage_tag[LAT-1];
            if (!flush && (|r_stage_tag[LAT-1])) begin
                r_resp_data <= w_stage_prod[LAT-1];
            end
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;

    // ------------------------------------------------------------------
    // Assertions
    // ------------------------------------------------------------------
    a_ready_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(req_ready));

    a_resp_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(resp_valid));

endmodule
